bayer_to_gray: RTL
==================

# bayer_to_gray

Converts the camera's raw Bayer pixel stream into the half-resolution 12-bit grayscale stream that feeds the edge-detection stage. Each 2x2 Bayer quad (G/R over B/G) is averaged into one gray pixel, and its coordinates are halved. A single line buffer of pair sums pairs the even row with the odd row. The block sits between the camera capture logic and the edge-detection stage. Its outputs drive that stage's pixel, valid and halved x/y counter inputs directly.

## Interface
- `IMG_W`, 1280: raw frame width in pixels; must be even.
- `IMG_H`, 960: raw frame height in pixels; must be even.
- `clk` input, 1 bit: single clock for all logic.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `raw_valid` input, 1 bit: qualifies `raw_pixel`, `raw_x` and `raw_y` in the current cycle.
- `raw_pixel` input, 12 bits: Bayer sample.
- `raw_x` input, 11 bits: column of the sample, 0..IMG_W-1.
- `raw_y` input, 11 bits: row of the sample, 0..IMG_H-1.
- `gray_valid` output, 1 bit: one-cycle strobe per output gray pixel.
- `gray_pixel` output, 12 bits: averaged quad value.
- `gray_x` output, 10 bits: `raw_x`>>1 of the quad.
- `gray_y` output, 10 bits: `raw_y`>>1 of the quad.
- `gray_sof` output, 1 bit: high together with `gray_valid` for the quad at (0,0).

## Operation
- An input beat is accepted only when `raw_valid`=1, `raw_x`<IMG_W and `raw_y`<IMG_H. All other beats are ignored and no state changes.
- **Pair register `p0`** (12 bits): on an accepted beat with even `raw_x`, `p0` captures `raw_pixel`.
- **Pair sum:** on an accepted beat with odd `raw_x`, `pair = p0 + raw_pixel`. This is 13 bits wide with no overflow.
- **Line buffer:** IMG_W/2 entries of 13 bits each, addressed by `raw_x`>>1.
  - On an even row at odd `raw_x`, write `pair` to the buffer.
  - On an odd row at odd `raw_x`, read the buffered entry: `sum = pair + linebuf[raw_x>>1]` (14 bits).
  - Then `gray_pixel` = `sum[13:2]`. This is truncation: no rounding, no saturation needed.
- **`line_ok` flag:**
  - Set on an accepted beat with even `raw_y` and `raw_x`=1.
  - Cleared by `rst`.
  - Cleared on an accepted beat with odd `raw_y` and `raw_x`=IMG_W-1, after that beat's output is produced.
- **Output rule:** a gray pixel is emitted on an odd-row, odd-`raw_x` beat only if `line_ok`=1. Otherwise the beat is consumed silently. This prevents stale buffer data from being emitted after a reset or a partial row.
- **Row sequence:**
  - Rows are expected in even/odd order.
  - Two consecutive even rows: the second overwrites the buffer.
  - An odd row with no preceding even row: no output.
- **Stalls:** `raw_valid` gaps of any length inside a pair or a row are legal. `p0` and the buffer hold their contents across a gap.
- `gray_sof` = 1 exactly when the emitted quad has `raw_x`>>1 = 0 and `raw_y`>>1 = 0.

## Timing
- **Reset values:**
  - `gray_valid`, `gray_pixel`, `gray_x`, `gray_y` and `gray_sof` are all 0.
  - `p0` and `line_ok` are 0.
  - Line-buffer contents are not reset.
- **Latency:** outputs are registered. `gray_valid` rises on the clock edge after the accepted odd-row, odd-x beat, and stays high for exactly 1 cycle per quad.
- **Throughput:**
  - Output rate is at most 1 gray pixel per 2 accepted beats on an odd row.
  - Output rate is 0 on even rows.
  - `gray_valid` is never high on two consecutive cycles.
- `gray_pixel`, `gray_x` and `gray_y` hold their last values while `gray_valid`=0.
- **Read-before-write:** a buffer read and a write to the same address never occur in the same cycle, because even and odd rows are disjoint.
- **Reset mid-operation:** `rst` asserted in any cycle clears all outputs immediately, since it is asynchronous. Output resumes only after a fresh even row sets `line_ok`.

## Test plan
- **Constant input:** all raw pixels = 4095 over a 1280x960 frame.
  - `gray_pixel` = 4095 for all 640x480 outputs.
  - The first output is at gray (0,0) with `gray_sof`=1.
- **Single-quad arithmetic:** raw (0,0)=100, (1,0)=200, (0,1)=300, (1,1)=400.
  - One cycle after the (1,1) beat: `gray_valid`=1, `gray_pixel`=250, `gray_x`=0, `gray_y`=0.
- **Truncation and coordinates:** quad values 1, 1, 1, 2 at raw (6..7, 10..11).
  - `gray_pixel`=1, `gray_x`=3, `gray_y`=5.
- **Valid gaps:** insert 0-5 idle cycles randomly between beats.
  - Gray values and coordinates match the gap-free reference model.
  - `gray_valid` count is 640 per odd row.
- **Reset mid-frame:** assert `rst` during an odd row.
  - Outputs go to 0.
  - The rest of that odd row produces no output.
  - The next even/odd row pair produces correct values.
- **Out-of-range beats:** beats with `raw_x`=1280 or `raw_y`=960 are interleaved with normal traffic.
  - No `gray_valid` is produced from them.
  - Buffer and `p0` results are unchanged.

Source files
------------

// File: rtl/bayer_to_gray.sv
// Bayer-to-grayscale converter: averages each 2x2 G/R/B/G quad into one 12-bit gray pixel
// at half resolution, pairing even and odd rows through a line buffer of horizontal pair sums.
module bayer_to_gray #(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 960
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        raw_valid,
    input  logic [11:0] raw_pixel,
    input  logic [10:0] raw_x,
    input  logic [10:0] raw_y,
    output logic        gray_valid,
    output logic [11:0] gray_pixel,
    output logic [9:0]  gray_x,
    output logic [9:0]  gray_y,
    output logic        gray_sof
);

    localparam int          HALF_W = IMG_W / 2;
    localparam logic [10:0] X_LIM  = 11'(IMG_W);
    localparam logic [10:0] Y_LIM  = 11'(IMG_H);
    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);

    logic [12:0] lineBuf [HALF_W];

    logic        accept;
    logic        bufWrite;
    logic        emit;
    logic [9:0]  bufAddr;
    logic [12:0] pairSum;
    logic [13:0] quadSum;

    logic [11:0] p0_q, p0_d;
    logic        lineOk_q, lineOk_d;
    logic        grayValid_q, grayValid_d;
    logic [11:0] grayPixel_q, grayPixel_d;
    logic [9:0]  grayX_q, grayX_d;
    logic [9:0]  grayY_q, grayY_d;
    logic        graySof_q, graySof_d;

    always_comb begin
        accept   = raw_valid && (raw_x < X_LIM) && (raw_y < Y_LIM);
        bufAddr  = raw_x[10:1];
        pairSum  = {1'b0, p0_q} + {1'b0, raw_pixel};
        quadSum  = {1'b0, pairSum} + {1'b0, lineBuf[bufAddr]};
        bufWrite = accept && raw_x[0] && !raw_y[0];
        emit     = accept && raw_x[0] && raw_y[0] && lineOk_q;
    end

    // line_ok is evaluated before the clear, so the last quad of the odd row still emits
    always_comb begin
        p0_d        = p0_q;
        lineOk_d    = lineOk_q;
        grayValid_d = 1'b0;
        graySof_d   = 1'b0;
        grayPixel_d = grayPixel_q;
        grayX_d     = grayX_q;
        grayY_d     = grayY_q;
        if (accept && !raw_x[0]) begin
            p0_d = raw_pixel;
        end
        if (accept && !raw_y[0] && (raw_x == 11'd1)) begin
            lineOk_d = 1'b1;
        end
        if (accept && raw_y[0] && (raw_x == X_LAST)) begin
            lineOk_d = 1'b0;
        end
        if (emit) begin
            grayValid_d = 1'b1;
            grayPixel_d = 12'(quadSum >> 2);
            grayX_d     = raw_x[10:1];
            grayY_d     = raw_y[10:1];
            graySof_d   = (raw_x[10:1] == 10'd0) && (raw_y[10:1] == 10'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q        <= 12'd0;
            lineOk_q    <= 1'b0;
            grayValid_q <= 1'b0;
            grayPixel_q <= 12'd0;
            grayX_q     <= 10'd0;
            grayY_q     <= 10'd0;
            graySof_q   <= 1'b0;
        end else begin
            p0_q        <= p0_d;
            lineOk_q    <= lineOk_d;
            grayValid_q <= grayValid_d;
            grayPixel_q <= grayPixel_d;
            grayX_q     <= grayX_d;
            grayY_q     <= grayY_d;
            graySof_q   <= graySof_d;
        end
    end

    // Buffer storage is left unreset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (bufWrite) begin
            lineBuf[bufAddr] <= pairSum;
        end
    end

    assign gray_valid = grayValid_q;
    assign gray_pixel = grayPixel_q;
    assign gray_x     = grayX_q;
    assign gray_y     = grayY_q;
    assign gray_sof   = graySof_q;

endmodule
